// File: rtl/fsm_path_driver.sv
// fsm_path_driver
//
// Drives a tracked 6-state FSM (codes A=000 .. F=101) along its shortest
// w-bit path to a requested target state, one w bit per cycle.
//
// Ports:
//   clk        - clock, all state changes on the rising edge
//   reset      - synchronous active-high reset
//   tgt        - requested target state code
//   req_valid  - tgt is valid this cycle
//   req_ready  - controller idle, request can be accepted
//   w          - serial FSM input bit (0 when w_valid is low)
//   w_valid    - w is qualified this cycle
//   y          - tracked FSM state
//   z          - FSM output, high in E or F
//   done       - one-cycle completion pulse
//   err        - illegal target (110/111) flag, qualified by done
//   steps      - w bits emitted for the completed request, qualified by done

module fsm_path_driver (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] tgt,
    input  logic       req_valid,
    output logic       req_ready,
    output logic       w,
    output logic       w_valid,
    output logic [2:0] y,
    output logic       z,
    output logic       done,
    output logic       err,
    output logic [1:0] steps
);

    localparam logic [2:0] StA = 3'b000;
    localparam logic [2:0] StB = 3'b001;
    localparam logic [2:0] StC = 3'b010;
    localparam logic [2:0] StD = 3'b011;
    localparam logic [2:0] StE = 3'b100;
    localparam logic [2:0] StF = 3'b101;

    typedef enum logic [1:0] {StIdle, StSend, StDone} ctrl_e;

    ctrl_e      state_q, state_d;
    logic [2:0] y_q, y_d;
    logic [2:0] tgt_q, tgt_d;
    logic [1:0] cnt_q, cnt_d;
    logic       err_q, err_d;
    logic [1:0] steps_q, steps_d;

    logic       hop_w;
    logic [2:0] y_next;

    // Next state of the tracked FSM.
    function automatic logic [2:0] fsm_next(input logic [2:0] cur, input logic win);
        logic [2:0] nxt;
        nxt = StA;
        case (cur)
            StA:     nxt = win ? StA : StB;
            StB:     nxt = win ? StD : StC;
            StC:     nxt = win ? StD : StE;
            StD:     nxt = win ? StA : StF;
            StE:     nxt = win ? StD : StE;
            StF:     nxt = win ? StD : StC;
            default: nxt = StA;
        endcase
        return nxt;
    endfunction

    // First w bit of the shortest path cur -> dst. Each row is indexed by the
    // target code; bits for cur==dst and for illegal codes are don't-care (0).
    function automatic logic first_hop(input logic [2:0] cur, input logic [2:0] dst);
        logic [7:0] row;
        row = 8'b0000_0000;
        case (cur)
            StA:     row = 8'b0000_0000;
            StB:     row = 8'b0010_1001;
            StC:     row = 8'b0010_1011;
            StD:     row = 8'b0000_0011;
            StE:     row = 8'b0010_1111;
            StF:     row = 8'b0000_1011;
            default: row = 8'b0000_0000;
        endcase
        return row[dst];
    endfunction

    assign hop_w  = first_hop(y_q, tgt_q);
    assign y_next = fsm_next(y_q, hop_w);

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        steps_d = steps_q;

        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    tgt_d = tgt;
                    cnt_d = 2'd0;
                    if (tgt >= 3'd6) begin
                        err_d   = 1'b1;
                        steps_d = 2'd0;
                        state_d = StDone;
                    end else if (tgt == y_q) begin
                        err_d   = 1'b0;
                        steps_d = 2'd0;
                        state_d = StDone;
                    end else begin
                        state_d = StSend;
                    end
                end
            end
            StSend: begin
                y_d   = y_next;
                cnt_d = cnt_q + 2'd1;
                if (y_next == tgt_q) begin
                    // Results publish only on reaching DONE so the previous
                    // request's err/steps stay visible throughout SEND.
                    err_d   = 1'b0;
                    steps_d = cnt_q + 2'd1;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            y_q     <= StA;
            tgt_q   <= 3'd0;
            cnt_q   <= 2'd0;
            err_q   <= 1'b0;
            steps_q <= 2'd0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            steps_q <= steps_d;
        end
    end

    // Handshake/strobe outputs are masked while reset is asserted so nothing
    // is offered or reported in a cycle that reset will discard.
    assign req_ready = (state_q == StIdle) && !reset;
    assign w_valid   = (state_q == StSend) && !reset;
    assign w         = w_valid & hop_w;
    assign done      = (state_q == StDone) && !reset;
    assign y         = y_q;
    assign z         = (y_q == StE) || (y_q == StF);
    assign err       = err_q;
    assign steps     = steps_q;

endmodule

// File: tb/tb_fsm_path_driver.sv
// tb_fsm_path_driver
//
// Directed bench for fsm_path_driver. Inputs change and outputs are sampled
// 1 time unit after each rising edge; expected values are hand-computed from
// the FSM transition and first-hop tables.

module tb_fsm_path_driver;

    logic       clk;
    logic       reset;
    logic [2:0] tgt;
    logic       req_valid;
    logic       req_ready;
    logic       w;
    logic       w_valid;
    logic [2:0] y;
    logic       z;
    logic       done;
    logic       err;
    logic [1:0] steps;

    int tests_run;
    int tests_failed;

    fsm_path_driver dut (
        .clk       (clk),
        .reset     (reset),
        .tgt       (tgt),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .w         (w),
        .w_valid   (w_valid),
        .y         (y),
        .z         (z),
        .done      (done),
        .err       (err),
        .steps     (steps)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle; returns in the first cycle after accept.
    task automatic send_req(input logic [2:0] t);
        tgt       = t;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    // One SEND cycle: check the emitted bit and the current y, then advance.
    task automatic expect_send(input string tag, input logic w_exp, input logic [2:0] y_exp);
        check_eq({tag, ".w_valid"}, {7'd0, w_valid}, 8'd1);
        check_eq({tag, ".w"}, {7'd0, w}, {7'd0, w_exp});
        check_eq({tag, ".y"}, {5'd0, y}, {5'd0, y_exp});
        check_eq({tag, ".done"}, {7'd0, done}, 8'd0);
        tick();
    endtask

    // DONE cycle: check results, then advance into IDLE.
    task automatic expect_done(input string tag, input logic [2:0] y_exp, input logic [1:0] st_exp,
                               input logic err_exp, input logic z_exp);
        check_eq({tag, ".done"}, {7'd0, done}, 8'd1);
        check_eq({tag, ".w_valid"}, {7'd0, w_valid}, 8'd0);
        check_eq({tag, ".ready"}, {7'd0, req_ready}, 8'd0);
        check_eq({tag, ".y"}, {5'd0, y}, {5'd0, y_exp});
        check_eq({tag, ".steps"}, {6'd0, steps}, {6'd0, st_exp});
        check_eq({tag, ".err"}, {7'd0, err}, {7'd0, err_exp});
        check_eq({tag, ".z"}, {7'd0, z}, {7'd0, z_exp});
        tick();
        check_eq({tag, ".done_off"}, {7'd0, done}, 8'd0);
        check_eq({tag, ".ready_back"}, {7'd0, req_ready}, 8'd1);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        tgt          = 3'd0;
        req_valid    = 1'b0;

        // Reset state
        tick();
        tick();
        check_eq("rst.y", {5'd0, y}, 8'd0);
        check_eq("rst.w", {7'd0, w}, 8'd0);
        check_eq("rst.w_valid", {7'd0, w_valid}, 8'd0);
        check_eq("rst.done", {7'd0, done}, 8'd0);
        check_eq("rst.err", {7'd0, err}, 8'd0);
        check_eq("rst.steps", {6'd0, steps}, 8'd0);
        check_eq("rst.z", {7'd0, z}, 8'd0);
        check_eq("rst.ready", {7'd0, req_ready}, 8'd0);
        reset = 1'b0;
        #1;
        check_eq("rst.ready_after", {7'd0, req_ready}, 8'd1);

        // A -> E: w=0,0,0
        send_req(3'b100);
        check_eq("ae.ready_busy", {7'd0, req_ready}, 8'd0);
        expect_send("ae0", 1'b0, 3'b000);
        expect_send("ae1", 1'b0, 3'b001);
        expect_send("ae2", 1'b0, 3'b010);
        expect_done("ae", 3'b100, 2'd3, 1'b0, 1'b1);

        // E -> B: w=1,1,0
        send_req(3'b001);
        check_eq("eb.steps_hold", {6'd0, steps}, 8'd3);
        expect_send("eb0", 1'b1, 3'b100);
        expect_send("eb1", 1'b1, 3'b011);
        expect_send("eb2", 1'b0, 3'b000);
        expect_done("eb", 3'b001, 2'd3, 1'b0, 1'b0);

        // B -> D: w=1
        send_req(3'b011);
        expect_send("bd0", 1'b1, 3'b001);
        expect_done("bd", 3'b011, 2'd1, 1'b0, 1'b0);

        // D -> D: done right after accept, no bits
        send_req(3'b011);
        expect_done("dd", 3'b011, 2'd0, 1'b0, 1'b0);

        // Illegal target: err, y unchanged; err holds afterwards
        send_req(3'b111);
        expect_done("ill", 3'b011, 2'd0, 1'b1, 1'b0);
        tick();
        check_eq("ill.err_hold", {7'd0, err}, 8'd1);

        // D -> A: w=1
        send_req(3'b000);
        expect_send("da0", 1'b1, 3'b011);
        expect_done("da", 3'b000, 2'd1, 1'b0, 1'b0);

        // req_valid held high, tgt 011 then 000
        tgt       = 3'b011;
        req_valid = 1'b1;
        tick();
        tgt = 3'b000;
        expect_send("h1.0", 1'b0, 3'b000);
        check_eq("h1.ready0", {7'd0, req_ready}, 8'd0);
        expect_send("h1.1", 1'b1, 3'b001);
        check_eq("h1.done", {7'd0, done}, 8'd1);
        check_eq("h1.y", {5'd0, y}, 8'h03);
        check_eq("h1.steps", {6'd0, steps}, 8'd2);
        check_eq("h1.w_valid", {7'd0, w_valid}, 8'd0);
        tick();
        check_eq("h2.idle_ready", {7'd0, req_ready}, 8'd1);
        check_eq("h2.idle_done", {7'd0, done}, 8'd0);
        tick();
        req_valid = 1'b0;
        expect_send("h2.0", 1'b1, 3'b011);
        expect_done("h2", 3'b000, 2'd1, 1'b0, 1'b0);

        // Reset during the second SEND cycle of A -> E
        send_req(3'b100);
        expect_send("ra0", 1'b0, 3'b000);
        check_eq("ra1.w_valid", {7'd0, w_valid}, 8'd1);
        reset = 1'b1;
        tick();
        check_eq("ra.y", {5'd0, y}, 8'd0);
        check_eq("ra.w_valid", {7'd0, w_valid}, 8'd0);
        check_eq("ra.done", {7'd0, done}, 8'd0);
        check_eq("ra.ready", {7'd0, req_ready}, 8'd0);
        check_eq("ra.steps", {6'd0, steps}, 8'd0);
        tick();
        reset = 1'b0;
        #1;
        check_eq("ra.ready_after", {7'd0, req_ready}, 8'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("ra.no_done", {7'd0, done}, 8'd0);
            check_eq("ra.no_w", {7'd0, w_valid}, 8'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fsm_path_driver.md
FSM_PATH_DRIVER -- requirements
Module: fsm_path_driver

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port tgt, input, 3 bits: requested target state code.
REQ-004 SHALL have port req_valid, input, 1 bit: tgt is valid this cycle.
REQ-005 SHALL have port req_ready, output, 1 bit: request can be accepted.
REQ-006 SHALL have port w, output, 1 bit: serial FSM input bit.
REQ-007 SHALL have port w_valid, output, 1 bit: w is qualified this cycle.
REQ-008 SHALL have port y, output, 3 bits: tracked FSM state.
REQ-009 SHALL have port z, output, 1 bit: FSM output.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse marking request completion.
REQ-011 SHALL have port err, output, 1 bit: illegal-target flag, qualified by done.
REQ-012 SHALL have port steps, output, 2 bits: number of w bits emitted for the completed request, qualified by done.

Function
REQ-013 SHALL track the 6-state FSM with codes A=000, B=001, C=010, D=011, E=100, F=101, written below as next state for w=0 / w=1: A:B/A, B:C/D, C:E/D, D:F/A, E:E/D, F:C/D.
REQ-014 SHALL drive z=1 only when y is E or F; z SHALL be combinational from y.
REQ-015 SHALL have controller states IDLE, SEND and DONE; req_ready=1 only in IDLE.
REQ-016 SHALL accept a request on a rising edge where req_valid and req_ready are both 1, latching tgt at that edge.
REQ-017 On acceptance with tgt=110 or 111, SHALL go to DONE with err=1 and steps=0, leaving y unchanged.
REQ-018 On acceptance with tgt equal to y, SHALL go to DONE with err=0 and steps=0, emitting no bits.
REQ-019 On any other acceptance, SHALL go to SEND.
REQ-020 In SEND, SHALL drive w_valid=1 with w equal to the first bit of the shortest path from y to the latched target.
REQ-021 In SEND, y SHALL update to next(y,w) at the edge and the step counter SHALL increment at the edge.
REQ-022 SHALL leave SEND for DONE at the edge where the updated y equals the target.
REQ-023 SHALL use this first-hop w table (tgt order A,B,C,D,E,F; "-" means cur=tgt):
  - A: -,0,0,0,0,0
  - B: 1,-,0,1,0,1
  - C: 1,1,-,1,0,1
  - D: 1,1,0,-,0,0
  - E: 1,1,1,1,-,1
  - F: 1,1,0,1,0,-
REQ-024 Maximum path length SHALL be 3 bits, so steps never exceeds 3.
REQ-025 SHALL drive w=0 whenever w_valid=0.
REQ-026 In DONE, SHALL hold done=1 for exactly one cycle with req_ready=0, then go to IDLE.
REQ-027 err and steps SHALL hold their values until the next request reaches DONE.
REQ-028 A request whose req_valid is held high during SEND or DONE SHALL NOT be accepted until IDLE.
REQ-029 Minimum request period SHALL be steps+2 cycles.
REQ-030 Latency SHALL be: accept at edge k gives bits in cycles k+1 to k+steps and done in cycle k+steps+1.

Reset
REQ-031 While reset=1 at an edge, SHALL set y=000 and controller=IDLE.
REQ-032 While reset=1 at an edge, SHALL clear the step counter, err and the latched target.
REQ-033 Reset outputs SHALL be w=0, w_valid=0, done=0, err=0, steps=0 and z=0.
REQ-034 req_ready SHALL be 0 in any cycle where reset=1 and 1 in the first cycle after reset deasserts.
REQ-035 Reset SHALL take priority over acceptance and over a SEND in progress; a reset mid-SEND SHALL abort the path with no done pulse.

Verification
REQ-036 Reset, then tgt=100 accepted -> w=0,0,0 with w_valid high for 3 cycles, y passes 001, 010, 100, then done=1, steps=3, err=0, z=1.
REQ-037 From y=100, tgt=001 -> w=1,1,0, y passes 011, 000, 001, then done=1, steps=3, z=0.
REQ-038 From y=011, tgt=011 -> done=1 in the cycle after accept, steps=0, w_valid never high.
REQ-039 tgt=111 accepted -> done=1, err=1, steps=0, y unchanged, w_valid never high.
REQ-040 reset=1 during the second SEND cycle of a path to 100 -> next cycle y=000, w_valid=0, done=0, req_ready=0; req_ready=1 the cycle after reset deasserts.
REQ-041 req_valid held high with tgt alternating 011 then 000 -> second request accepted only in the IDLE cycle after done; paths are w=0,1 then w=1, with done pulses 3 cycles and 3 cycles apart respectively.
